// File: rtl/gen_step_controller.sv
// Generation-step controller: paces the Game of Life engine with selectable
// speed levels, single-step while paused, a go/done handshake and a
// generation counter.
module gen_step_controller #(
  parameter int unsigned BASE_CNT   = 4,
  parameter int unsigned N_SPEEDS   = 3,
  parameter int unsigned INIT_SPEED = 0,
  parameter int unsigned GEN_W      = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            i_NFI_allowed,
  input  logic                                            i_cmd_toggle_pause,
  input  logic                                            i_cmd_step,
  input  logic                                            i_cmd_speed_up,
  input  logic                                            i_cmd_speed_down,
  input  logic                                            i_done,
  output logic                                            o_go,
  output logic                                            o_busy,
  output logic                                            o_paused,
  output logic [((N_SPEEDS > 1) ? $clog2(N_SPEEDS) : 1)-1:0] o_speed,
  output logic [GEN_W-1:0]                                o_gen_cnt
);

  localparam int unsigned SPD_W = (N_SPEEDS > 1) ? $clog2(N_SPEEDS) : 1;
  localparam int unsigned CNT_W = $clog2(BASE_CNT << (N_SPEEDS - 1));

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [SPD_W-1:0]   speed_q, speed_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               paused_q, paused_d;
  logic               pend_q, pend_d;
  logic               go_q, go_d;

  logic [CNT_W-1:0]   lim_c;
  logic               expired_c;
  logic               launch_c;
  logic               spd_up_c;
  logic               spd_dn_c;

  // Terminal timer value for the current speed level: P(s)-1
  assign lim_c = CNT_W'((32'(BASE_CNT) << (32'(N_SPEEDS - 1) - 32'(speed_q))) - 32'd1);

  assign expired_c = (timer_q == lim_c);

  // A generation starts when the engine is idle and allowed and either the
  // timer has expired (running) or a step is pending (paused)
  assign launch_c = (state_q == IDLE) && i_NFI_allowed &&
                    (paused_q ? pend_q : expired_c);

  // Speed requests that actually change the level; simultaneous up/down cancel
  assign spd_up_c = i_cmd_speed_up && !i_cmd_speed_down &&
                    (speed_q < SPD_W'(N_SPEEDS - 1));
  assign spd_dn_c = i_cmd_speed_down && !i_cmd_speed_up &&
                    (speed_q != '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      speed_q  <= SPD_W'(INIT_SPEED);
      gen_q    <= '0;
      paused_q <= 1'b1;
      pend_q   <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      speed_q  <= speed_d;
      gen_q    <= gen_d;
      paused_q <= paused_d;
      pend_q   <= pend_d;
      go_q     <= go_d;
    end
  end

  // Handshake FSM: launch a generation, then wait for the engine's done
  always_comb begin
    state_d = state_q;
    go_d    = 1'b0;
    gen_d   = gen_q;
    case (state_q)
      IDLE: begin
        if (launch_c) begin
          state_d = WAIT_DONE;
          go_d    = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (i_done) begin
          state_d = IDLE;
          gen_d   = gen_q + GEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Period timer, pause/step bookkeeping and speed level
  always_comb begin
    timer_d  = timer_q;
    paused_d = paused_q ^ i_cmd_toggle_pause;
    pend_d   = pend_q;
    speed_d  = speed_q;

    if (spd_up_c) begin
      speed_d = speed_q + SPD_W'(1);
    end else if (spd_dn_c) begin
      speed_d = speed_q - SPD_W'(1);
    end

    if (i_cmd_toggle_pause || spd_up_c || spd_dn_c || launch_c || paused_q) begin
      timer_d = '0;
    end else if (!expired_c) begin
      timer_d = timer_q + CNT_W'(1);
    end

    // Toggle wins over a simultaneous step; steps while busy or already
    // pending are absorbed
    if (i_cmd_toggle_pause || launch_c) begin
      pend_d = 1'b0;
    end else if (paused_q && (state_q == IDLE) && i_cmd_step) begin
      pend_d = 1'b1;
    end
  end

  assign o_go      = go_q;
  assign o_busy    = (state_q == WAIT_DONE);
  assign o_paused  = paused_q;
  assign o_speed   = speed_q;
  assign o_gen_cnt = gen_q;

endmodule
